gf_tree_adder_pipe: RTL and testbench

//  Pipelined, flow-controlled GF(2^m) reduction tree. XORs NUM_INPUTS lanes per beat and

---
 rtl/gf_tree_adder_pipe_pkg.sv | 27 ++
 rtl/gf_tree_adder_pipe_if.sv | 28 ++
 rtl/gf_xor_tree_stage.sv | 66 ++++++
 rtl/gf_tree_adder_pipe.sv | 154 +++++++++++++++
 tb/tb_gf_tree_adder_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf_tree_adder_pipe_pkg.sv
// Shared GF(2^m) helpers and elaboration-time sizing for the pipelined tree adder.
package gf_tree_adder_pipe_pkg;

    localparam int SYM_W    = 8;
    localparam int GF_MAX_W = 64;

    function automatic logic [GF_MAX_W-1:0] gf_add(input logic [GF_MAX_W-1:0] a,
                                                    input logic [GF_MAX_W-1:0] b);
        return a ^ b;
    endfunction

    function automatic int tree_levels(input int num_inputs);
        return (num_inputs <= 1) ? 0 : $clog2(num_inputs);
    endfunction

    function automatic int tree_stages(input int levels, input int per_stage);
        return (levels + per_stage - 1) / per_stage;
    endfunction

    // The last stage may hold fewer than per_stage levels.
    function automatic int stage_depth(input int levels, input int per_stage, input int stage);
        int remaining;
        remaining = levels - stage * per_stage;
        return (remaining < per_stage) ? remaining : per_stage;
    endfunction

endpackage

// File: rtl/gf_tree_adder_pipe_if.sv
// Beat stream in, frame result out, for the GF tree adder.
interface gf_tree_adder_pipe_if
    import gf_tree_adder_pipe_pkg::*;
#(
    parameter int NUM_INPUTS = 16,
    parameter int DATA_WIDTH = SYM_W,
    parameter int CNT_WIDTH  = 8
);
    logic                             in_valid;
    logic                             in_ready;
    logic                             in_sop;
    logic                             in_eop;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH-1:0]            data_out;
    logic [CNT_WIDTH-1:0]             out_beats;

    modport master (
        output in_valid, in_sop, in_eop, data_in, out_ready,
        input  in_ready, out_valid, data_out, out_beats
    );

    modport slave (
        input  in_valid, in_sop, in_eop, data_in, out_ready,
        output in_ready, out_valid, data_out, out_beats
    );
endinterface

// File: rtl/gf_xor_tree_stage.sv
// One LEVELS-deep XOR reduction slice followed by its enabled pipeline register.
module gf_xor_tree_stage
    import gf_tree_adder_pipe_pkg::*;
#(
    parameter  int IN_LANES   = 4,
    parameter  int LEVELS     = 2,
    parameter  int DATA_WIDTH = SYM_W,
    localparam int OUT_LANES  = IN_LANES >> LEVELS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            in_valid,
    input  logic                            in_sop,
    input  logic                            in_eop,
    input  logic [IN_LANES*DATA_WIDTH-1:0]  in_data,
    output logic                            out_valid,
    output logic                            out_sop,
    output logic                            out_eop,
    output logic [OUT_LANES*DATA_WIDTH-1:0] out_data
);

    logic [DATA_WIDTH-1:0]            work_s [IN_LANES];
    logic [OUT_LANES*DATA_WIDTH-1:0]  reduced_s;
    logic [OUT_LANES*DATA_WIDTH-1:0]  data_r;
    logic                             valid_r;
    logic                             sop_r;
    logic                             eop_r;

    // In-place pairwise reduction: entry j of level k is pair (2j, 2j+1) of level k-1.
    always_comb begin
        reduced_s = '0;
        for (int i = 0; i < IN_LANES; i++) begin
            work_s[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int k = 0; k < LEVELS; k++) begin
            for (int j = 0; j < (IN_LANES >> (k + 1)); j++) begin
                work_s[j] = DATA_WIDTH'(gf_add(GF_MAX_W'(work_s[2*j]), GF_MAX_W'(work_s[2*j+1])));
            end
        end
        for (int j = 0; j < OUT_LANES; j++) begin
            reduced_s[j*DATA_WIDTH +: DATA_WIDTH] = work_s[j];
        end
    end

    // Stage register; the whole pipeline advances together on en.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            sop_r   <= 1'b0;
            eop_r   <= 1'b0;
            data_r  <= '0;
        end else if (en) begin
            valid_r <= in_valid;
            sop_r   <= in_sop;
            eop_r   <= in_eop;
            data_r  <= reduced_s;
        end
    end

    assign out_valid = valid_r;
    assign out_sop   = sop_r;
    assign out_eop   = eop_r;
    assign out_data  = data_r;

endmodule

// File: rtl/gf_tree_adder_pipe.sv
// Pipelined, flow-controlled GF(2^m) reduction tree with per-frame accumulation.
module gf_tree_adder_pipe
    import gf_tree_adder_pipe_pkg::*;
#(
    parameter int NUM_INPUTS   = 16,
    parameter int DATA_WIDTH   = SYM_W,
    parameter int STAGE_LEVELS = 2,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    gf_tree_adder_pipe_if.slave  bus
);

    localparam int L      = tree_levels(NUM_INPUTS);
    localparam int P      = tree_stages(L, STAGE_LEVELS);
    localparam int PADDED = 1 << L;

    logic                         adv_s;
    logic [PADDED*DATA_WIDTH-1:0] padded_s;
    logic [DATA_WIDTH-1:0]        tree_sum_s;
    logic                         tree_valid_s;
    logic                         tree_sop_s;
    logic                         tree_eop_s;

    logic [DATA_WIDTH-1:0]        acc_r;
    logic [CNT_WIDTH-1:0]         cnt_r;
    logic                         out_valid_r;
    logic [DATA_WIDTH-1:0]        data_out_r;
    logic [CNT_WIDTH-1:0]         out_beats_r;
    logic [DATA_WIDTH-1:0]        next_acc_s;
    logic [CNT_WIDTH-1:0]         next_cnt_s;

    // Global stall: nothing moves while a result waits on downstream.
    assign adv_s        = ~out_valid_r | bus.out_ready;
    assign bus.in_ready = adv_s;

    // Zero-pad the lanes up to the next power of two.
    always_comb begin
        padded_s = '0;
        padded_s[NUM_INPUTS*DATA_WIDTH-1:0] = bus.data_in;
    end

    generate
        if (P == 0) begin : g_no_tree
            assign tree_sum_s   = padded_s;
            assign tree_valid_s = bus.in_valid;
            assign tree_sop_s   = bus.in_sop;
            assign tree_eop_s   = bus.in_eop;
        end else begin : g_tree
            for (genvar s = 0; s < P; s++) begin : g_stage
                localparam int IN_LANES  = PADDED >> (s * STAGE_LEVELS);
                localparam int LVLS      = stage_depth(L, STAGE_LEVELS, s);
                localparam int OUT_LANES = IN_LANES >> LVLS;

                logic [IN_LANES*DATA_WIDTH-1:0]  in_data_s;
                logic                            in_valid_s;
                logic                            in_sop_s;
                logic                            in_eop_s;
                logic [OUT_LANES*DATA_WIDTH-1:0] out_data_s;
                logic                            out_valid_s;
                logic                            out_sop_s;
                logic                            out_eop_s;

                if (s == 0) begin : g_head
                    assign in_data_s  = padded_s;
                    assign in_valid_s = bus.in_valid;
                    assign in_sop_s   = bus.in_sop;
                    assign in_eop_s   = bus.in_eop;
                end else begin : g_link
                    assign in_data_s  = g_stage[s-1].out_data_s;
                    assign in_valid_s = g_stage[s-1].out_valid_s;
                    assign in_sop_s   = g_stage[s-1].out_sop_s;
                    assign in_eop_s   = g_stage[s-1].out_eop_s;
                end

                gf_xor_tree_stage #(
                    .IN_LANES   (IN_LANES),
                    .LEVELS     (LVLS),
                    .DATA_WIDTH (DATA_WIDTH)
                ) u_stage (
                    .clk       (clk),
                    .rst       (rst),
                    .en        (adv_s),
                    .in_valid  (in_valid_s),
                    .in_sop    (in_sop_s),
                    .in_eop    (in_eop_s),
                    .in_data   (in_data_s),
                    .out_valid (out_valid_s),
                    .out_sop   (out_sop_s),
                    .out_eop   (out_eop_s),
                    .out_data  (out_data_s)
                );
            end

            assign tree_sum_s   = g_stage[P-1].out_data_s;
            assign tree_valid_s = g_stage[P-1].out_valid_s;
            assign tree_sop_s   = g_stage[P-1].out_sop_s;
            assign tree_eop_s   = g_stage[P-1].out_eop_s;
        end
    endgenerate

    // sop restarts the frame from zero, discarding any partial sum.
    always_comb begin
        logic [DATA_WIDTH-1:0] base_acc;
        logic [CNT_WIDTH-1:0]  base_cnt;
        if (tree_sop_s) begin
            base_acc = '0;
            base_cnt = '0;
        end else begin
            base_acc = acc_r;
            base_cnt = cnt_r;
        end
        next_acc_s = DATA_WIDTH'(gf_add(GF_MAX_W'(base_acc), GF_MAX_W'(tree_sum_s)));
        if (&base_cnt) begin
            next_cnt_s = base_cnt;
        end else begin
            next_cnt_s = base_cnt + CNT_WIDTH'(1);
        end
    end

    // Accumulator and result register; result stays held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            data_out_r  <= '0;
            out_beats_r <= '0;
        end else if (adv_s) begin
            if (tree_valid_s && tree_eop_s) begin
                out_valid_r <= 1'b1;
                data_out_r  <= next_acc_s;
                out_beats_r <= next_cnt_s;
                acc_r       <= '0;
                cnt_r       <= '0;
            end else begin
                out_valid_r <= 1'b0;
                if (tree_valid_s) begin
                    acc_r <= next_acc_s;
                    cnt_r <= next_cnt_s;
                end else begin
                    acc_r <= acc_r;
                    cnt_r <= cnt_r;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.data_out  = data_out_r;
    assign bus.out_beats = out_beats_r;

endmodule

// File: tb/tb_gf_tree_adder_pipe.sv
// Scoreboard bench: three builds (16 lanes, 5 lanes, 2-bit beat counter) share one stimulus path.
module tb_gf_tree_adder_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_s;
    logic         in_sop_s;
    logic         in_eop_s;
    logic         out_ready_s;
    logic [127:0] data_s;
    int           sel;

    int errors = 0;
    int checks = 0;
    int m_acc [3];
    int m_cnt [3];
    int cnt_max [3] = '{255, 255, 3};
    int nlanes  [3] = '{16, 5, 16};
    int recv    [3] = '{0, 0, 0};
    logic [15:0] q_a [$];
    logic [15:0] q_b [$];
    logic [15:0] q_c [$];

    always #5 clk = ~clk;

    gf_tree_adder_pipe_if #(.NUM_INPUTS(16), .DATA_WIDTH(8), .CNT_WIDTH(8)) bus_a ();
    gf_tree_adder_pipe_if #(.NUM_INPUTS(5),  .DATA_WIDTH(8), .CNT_WIDTH(8)) bus_b ();
    gf_tree_adder_pipe_if #(.NUM_INPUTS(16), .DATA_WIDTH(8), .CNT_WIDTH(2)) bus_c ();

    assign bus_a.in_valid  = in_valid_s && (sel == 0);
    assign bus_a.in_sop    = in_sop_s;
    assign bus_a.in_eop    = in_eop_s;
    assign bus_a.data_in   = data_s;
    assign bus_a.out_ready = out_ready_s;
    assign bus_b.in_valid  = in_valid_s && (sel == 1);
    assign bus_b.in_sop    = in_sop_s;
    assign bus_b.in_eop    = in_eop_s;
    assign bus_b.data_in   = data_s[39:0];
    assign bus_b.out_ready = out_ready_s;
    assign bus_c.in_valid  = in_valid_s && (sel == 2);
    assign bus_c.in_sop    = in_sop_s;
    assign bus_c.in_eop    = in_eop_s;
    assign bus_c.data_in   = data_s;
    assign bus_c.out_ready = out_ready_s;

    gf_tree_adder_pipe #(.NUM_INPUTS(16), .DATA_WIDTH(8), .STAGE_LEVELS(2), .CNT_WIDTH(8))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    gf_tree_adder_pipe #(.NUM_INPUTS(5), .DATA_WIDTH(8), .STAGE_LEVELS(2), .CNT_WIDTH(8))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    gf_tree_adder_pipe #(.NUM_INPUTS(16), .DATA_WIDTH(8), .STAGE_LEVELS(2), .CNT_WIDTH(2))
        u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] beat_sum(input logic [127:0] d, input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s = s ^ d[i*8 +: 8];
        return s;
    endfunction

    function automatic logic cur_ready(input int id);
        case (id)
            0:       return bus_a.in_ready;
            1:       return bus_b.in_ready;
            default: return bus_c.in_ready;
        endcase
    endfunction

    function automatic logic cur_out_valid(input int id);
        case (id)
            0:       return bus_a.out_valid;
            1:       return bus_b.out_valid;
            default: return bus_c.out_valid;
        endcase
    endfunction

    task automatic model_accept(input int id, input logic sop, input logic eop, input logic [127:0] d);
        logic [15:0] e;
        if (sop) begin
            m_acc[id] = 0;
            m_cnt[id] = 0;
        end
        m_acc[id] = m_acc[id] ^ int'(beat_sum(d, nlanes[id]));
        if (m_cnt[id] < cnt_max[id]) m_cnt[id]++;
        if (eop) begin
            e = {m_cnt[id][7:0], m_acc[id][7:0]};
            case (id)
                0:       q_a.push_back(e);
                1:       q_b.push_back(e);
                default: q_c.push_back(e);
            endcase
            m_acc[id] = 0;
            m_cnt[id] = 0;
        end
    endtask

    // Called and returns at negedge+1; holds the beat until accepted.
    task automatic send(input logic sop, input logic eop, input logic [127:0] d);
        int waited = 0;
        in_valid_s = 1'b1;
        in_sop_s   = sop;
        in_eop_s   = eop;
        data_s     = d;
        #1;
        while (!cur_ready(sel) && waited < 100) begin
            @(negedge clk);
            #2;
            waited++;
        end
        if (waited >= 100) begin
            chk("send_timeout", 32'd1, 32'd0);
        end else begin
            model_accept(sel, sop, eop, d);
            @(negedge clk);
        end
        #1;
        in_valid_s = 1'b0;
        in_sop_s   = 1'b0;
        in_eop_s   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end
        q_a.delete();
        q_b.delete();
        q_c.delete();
    endtask

    task automatic wait_out(input int id, output int lat);
        int n = 0;
        while (!cur_out_valid(id) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("out_timeout", 32'd1, 32'd0);
        lat = n + 1;
    endtask

    // Output monitor for the 16-lane build, including stall hold and ready rule.
    logic       a_hold = 1'b0;
    logic [7:0] a_prev_d;
    logic [7:0] a_prev_b;
    always @(negedge clk) begin
        logic [15:0] e;
        #3;
        if (rst) begin
            a_hold = 1'b0;
        end else begin
            chk("a_in_ready", bus_a.in_ready, !bus_a.out_valid || out_ready_s);
            if (a_hold) begin
                chk("a_hold_valid", bus_a.out_valid, 1'b1);
                chk("a_hold_data", bus_a.data_out, a_prev_d);
                chk("a_hold_beats", bus_a.out_beats, a_prev_b);
            end
            if (bus_a.out_valid && out_ready_s) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q_a.pop_front();
                    chk("a_data", bus_a.data_out, e[7:0]);
                    chk("a_beats", bus_a.out_beats, e[15:8]);
                    recv[0]++;
                end
            end
            a_hold   = bus_a.out_valid && !out_ready_s;
            a_prev_d = bus_a.data_out;
            a_prev_b = bus_a.out_beats;
        end
    end

    // Output monitors for the 5-lane and 2-bit-counter builds.
    always @(negedge clk) begin
        logic [15:0] e;
        #3;
        if (!rst && bus_b.out_valid && out_ready_s) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                chk("b_data", bus_b.data_out, e[7:0]);
                chk("b_beats", bus_b.out_beats, e[15:8]);
                recv[1]++;
            end
        end
        if (!rst && bus_c.out_valid && out_ready_s) begin
            if (q_c.size() == 0) begin
                chk("c_unexpected", 32'd1, 32'd0);
            end else begin
                e = q_c.pop_front();
                chk("c_data", bus_c.data_out, e[7:0]);
                chk("c_beats", bus_c.out_beats, e[15:8]);
                recv[2]++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           r0;
        int           waited;
        logic [127:0] d;

        rst         = 1'b1;
        in_valid_s  = 1'b0;
        in_sop_s    = 1'b0;
        in_eop_s    = 1'b0;
        data_s      = '0;
        out_ready_s = 1'b1;
        sel         = 0;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end
        idle(2);
        rst = 1'b0;
        idle(1);

        chk("rst_a_valid", bus_a.out_valid, 1'b0);
        chk("rst_a_ready", bus_a.in_ready, 1'b1);
        chk("rst_a_data", bus_a.data_out, 8'h00);
        chk("rst_a_beats", bus_a.out_beats, 8'h00);
        chk("rst_b_valid", bus_b.out_valid, 1'b0);
        chk("rst_c_valid", bus_c.out_valid, 1'b0);

        // Single-beat frame.
        sel = 0;
        d = '0;
        d[7:0] = 8'hA5;
        send(1'b1, 1'b1, d);
        wait_out(0, lat);
        chk("t1_latency", lat, 3);
        chk("t1_data", bus_a.data_out, 8'hA5);
        chk("t1_beats", bus_a.out_beats, 8'd1);
        idle(3);

        // Two-beat frame, gap between beats; nothing may appear after beat 1.
        d = '0;
        d[15:8]  = 8'h30;
        d[63:56] = 8'h0C;
        send(1'b1, 1'b0, d);
        idle(5);
        chk("t2_no_early", bus_a.out_valid, 1'b0);
        d = '0;
        d[127:120] = 8'h0F;
        send(1'b0, 1'b1, d);
        wait_out(0, lat);
        chk("t2_latency", lat, 3);
        chk("t2_data", bus_a.data_out, 8'h33);
        chk("t2_beats", bus_a.out_beats, 8'd2);
        idle(3);

        // Five-lane build, non-power-of-two padding.
        sel = 1;
        d = '0;
        d[39:0] = 40'h10_08_04_02_01;
        send(1'b1, 1'b1, d);
        wait_out(1, lat);
        chk("t3_latency", lat, 3);
        chk("t3_data", bus_b.data_out, 8'h1F);
        chk("t3_beats", bus_b.out_beats, 8'd1);
        idle(3);

        // 20 back-to-back frames with a downstream stall window.
        sel = 0;
        r0 = recv[0];
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
                end
            end
            begin
                repeat (5) @(negedge clk);
                #1 out_ready_s = 1'b0;
                repeat (10) @(negedge clk);
                #1 out_ready_s = 1'b1;
            end
        join
        waited = 0;
        while (q_a.size() != 0 && waited < 50) begin
            idle(1);
            waited++;
        end
        idle(3);
        chk("t4_drain", q_a.size(), 0);
        chk("t4_count", recv[0] - r0, 20);

        // Reset mid-frame discards in-flight beats.
        d = '0;
        d[7:0] = 8'h22;
        send(1'b1, 1'b0, d);
        d[7:0] = 8'h44;
        send(1'b0, 1'b0, d);
        reset_dut();
        chk("t5_valid_after_rst", bus_a.out_valid, 1'b0);
        chk("t5_ready_after_rst", bus_a.in_ready, 1'b1);
        idle(6);
        chk("t5_no_result", bus_a.out_valid, 1'b0);
        d[7:0] = 8'h11;
        send(1'b1, 1'b1, d);
        wait_out(0, lat);
        chk("t5_data", bus_a.data_out, 8'h11);
        chk("t5_beats", bus_a.out_beats, 8'd1);
        idle(3);

        // Saturating 2-bit beat counter, then sop arriving mid-frame.
        sel = 2;
        d = '0;
        d[7:0] = 8'h01;
        send(1'b1, 1'b0, d);
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, d);
        send(1'b0, 1'b1, d);
        wait_out(2, lat);
        chk("t6_latency", lat, 3);
        chk("t6_data", bus_c.data_out, 8'h01);
        chk("t6_beats", bus_c.out_beats, 2'd3);
        idle(3);
        d[7:0] = 8'h05;
        send(1'b1, 1'b0, d);
        d[7:0] = 8'h06;
        send(1'b0, 1'b0, d);
        d[7:0] = 8'h40;
        send(1'b1, 1'b0, d);
        d[7:0] = 8'h02;
        send(1'b0, 1'b1, d);
        wait_out(2, lat);
        chk("t6_restart_data", bus_c.data_out, 8'h42);
        chk("t6_restart_beats", bus_c.out_beats, 2'd2);
        idle(5);

        chk("end_queues", q_a.size() + q_b.size() + q_c.size(), 0);
        chk("end_recv_c", recv[2], 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
